// File: rtl/req_gnt_pkg.sv
// Shared defaults and per-requester state record
// for the deadline-driven grant scheduler.
package req_gnt_pkg;

    localparam int N_REQ_DEF    = 4;
    localparam int MIN_WAIT_DEF = 3;
    localparam int WINDOW_DEF   = 8;
    localparam int AGE_W        = $clog2(MIN_WAIT_DEF + WINDOW_DEF + 1);

    typedef struct packed {
        logic             pending;
        logic [AGE_W-1:0] age;
    } req_state_t;

endpackage

// File: rtl/req_gnt_sched_pick.sv
// Oldest-first selector: largest age among eligible
// requesters wins, ties go to the lowest index.
module req_gnt_pick #(
    parameter int N_REQ = 4,
    parameter int AW    = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0]    elig,
    input  logic [N_REQ*AW-1:0] ages,
    output logic                valid,
    output logic [IW-1:0]       id
);

    logic [AW-1:0] best;
    logic [AW-1:0] cur;

    always_comb begin
        valid = 1'b0;
        id    = '0;
        best  = '0;
        cur   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cur = ages[i*AW +: AW];
            // strict compare keeps the lower index on a tie
            if (elig[i] && (!valid || cur > best)) begin
                valid = 1'b1;
                id    = IW'(i);
                best  = cur;
            end
        end
    end

endmodule

// File: rtl/req_gnt_sched.sv
// Grant scheduler: every accepted request gets one gnt
// pulse inside its window, oldest eligible first.
module req_gnt_sched
    import req_gnt_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MIN_WAIT = MIN_WAIT_DEF,
    parameter int WINDOW   = WINDOW_DEF,
    parameter int AW       = $clog2(MIN_WAIT + WINDOW + 1),
    localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             hold,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_id,
    output logic             busy,
    output logic             dup_err,
    output logic             miss,
    output logic [IW-1:0]    miss_id
);

    localparam logic [AGE_W-1:0] AGE_LO = AGE_W'(MIN_WAIT - 1);
    localparam logic [AGE_W-1:0] AGE_HI = AGE_W'(MIN_WAIT + WINDOW - 2);

    req_state_t st_q [N_REQ];
    req_state_t st_d [N_REQ];

    logic [N_REQ-1:0]    elig;
    logic [N_REQ-1:0]    pend;
    logic [N_REQ-1:0]    expire;
    logic [N_REQ-1:0]    gnt_d;
    logic [N_REQ*AW-1:0] ages;
    logic                pick_valid;
    logic [IW-1:0]       pick_id;
    logic [IW-1:0]       miss_id_d;
    logic                do_gnt;

    always_comb begin
        elig = '0;
        pend = '0;
        ages = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pend[i] = st_q[i].pending;
            elig[i] = st_q[i].pending
                   && st_q[i].age >= AGE_LO
                   && st_q[i].age <= AGE_HI;
            ages[i*AW +: AW] = AW'(st_q[i].age);
        end
    end

    req_gnt_pick #(
        .N_REQ (N_REQ),
        .AW    (AW),
        .IW    (IW)
    ) u_pick (
        .elig  (elig),
        .ages  (ages),
        .valid (pick_valid),
        .id    (pick_id)
    );

    always_comb begin
        do_gnt = pick_valid && !hold;
        gnt_d  = '0;
        if (do_gnt) gnt_d[pick_id] = 1'b1;

        expire    = '0;
        miss_id_d = '0;
        // walk downwards so the lowest expiring index is reported
        for (int i = N_REQ - 1; i >= 0; i--) begin
            expire[i] = st_q[i].pending
                     && st_q[i].age == AGE_HI
                     && !gnt_d[i];
            if (expire[i]) miss_id_d = IW'(i);
        end

        for (int i = 0; i < N_REQ; i++) begin
            st_d[i] = st_q[i];
            if (st_q[i].pending) begin
                if (gnt_d[i] || expire[i]) begin
                    st_d[i] = '0;
                end else if (st_q[i].age != AGE_HI) begin
                    st_d[i].age = st_q[i].age + 1'b1;
                end
            end else if (req[i]) begin
                st_d[i].pending = 1'b1;
                st_d[i].age     = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) st_q[i] <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            dup_err <= 1'b0;
            miss    <= 1'b0;
            miss_id <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) st_q[i] <= st_d[i];
            gnt     <= gnt_d;
            gnt_id  <= do_gnt ? pick_id : '0;
            busy    <= |pend;
            dup_err <= |(req & pend);
            miss    <= |expire;
            miss_id <= miss_id_d;
        end
    end

endmodule

// File: tb/tb_req_gnt_sched.sv
// Directed self-checking bench for req_gnt_sched.
// k counts edges after the req sample edge T.
module tb_req_gnt_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       dup_err;
    logic       miss;
    logic [1:0] miss_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    req_gnt_sched dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .hold    (hold),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .dup_err (dup_err),
        .miss    (miss),
        .miss_id (miss_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] all;
        rst = 1'b0; req = 4'b1111; hold = 1'b0;
        tick(); tick();
        all = {gnt, gnt_id, busy, dup_err, miss, miss_id};
        checks++;
        if (all !== 11'd0) begin
            errors++;
            $display("FAIL reset_outs got %b exp 0", all);
        end
        rst = 1'b1; req = 4'b0000;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle busy %b gnt %b exp 0", busy, gnt);
        end
    endtask

    task automatic test_single();
        logic [3:0] e;
        for (int k = 0; k < 13; k++) begin
            req = (k == 0) ? 4'b0001 : 4'b0000;
            tick();
            req = 4'b0000;
            e = (k == 3) ? 4'b0001 : 4'b0000;
            checks++;
            if (gnt !== e) begin
                errors++;
                $display("FAIL single_gnt k=%0d got %b exp %b", k, gnt, e);
            end
            if (k == 3) begin
                checks++;
                if (gnt_id !== 2'd0) begin
                    errors++;
                    $display("FAIL single_id got %0d exp 0", gnt_id);
                end
            end
            checks++;
            if (busy !== (k >= 1 && k <= 3)) begin
                errors++;
                $display("FAIL single_busy k=%0d got %b", k, busy);
            end
            checks++;
            if (miss !== 1'b0) begin
                errors++;
                $display("FAIL single_miss k=%0d got %b exp 0", k, miss);
            end
        end
    endtask

    task automatic test_all();
        logic [3:0] e;
        logic [1:0] ei;
        for (int k = 0; k < 13; k++) begin
            req = (k == 0) ? 4'b1111 : 4'b0000;
            tick();
            req = 4'b0000;
            e  = 4'b0000;
            ei = 2'd0;
            if (k >= 3 && k <= 6) begin
                e  = 4'b0001 << (k - 3);
                ei = 2'(k - 3);
            end
            checks++;
            if (gnt !== e) begin
                errors++;
                $display("FAIL all_gnt k=%0d got %b exp %b", k, gnt, e);
            end
            if (k >= 3 && k <= 6) begin
                checks++;
                if (gnt_id !== ei) begin
                    errors++;
                    $display("FAIL all_id k=%0d got %0d exp %0d", k, gnt_id, ei);
                end
            end
            checks++;
            if (miss !== 1'b0) begin
                errors++;
                $display("FAIL all_miss k=%0d got %b exp 0", k, miss);
            end
        end
    endtask

    task automatic test_stagger();
        logic [3:0] e;
        for (int k = 0; k < 12; k++) begin
            req = (k == 0) ? 4'b0010 : (k == 2) ? 4'b0001 : 4'b0000;
            tick();
            req = 4'b0000;
            e = (k == 3) ? 4'b0010 : (k == 5) ? 4'b0001 : 4'b0000;
            checks++;
            if (gnt !== e) begin
                errors++;
                $display("FAIL stagger_gnt k=%0d got %b exp %b", k, gnt, e);
            end
            if (k == 3 || k == 5) begin
                checks++;
                if (gnt_id !== ((k == 3) ? 2'd1 : 2'd0)) begin
                    errors++;
                    $display("FAIL stagger_id k=%0d got %0d", k, gnt_id);
                end
            end
        end
    endtask

    task automatic test_oldest();
        logic [3:0] e;
        for (int k = 0; k < 12; k++) begin
            req  = (k == 0) ? 4'b1000 : (k == 1) ? 4'b0001 : 4'b0000;
            hold = (k <= 4);
            tick();
            req = 4'b0000;
            e = (k == 5) ? 4'b1000 : (k == 6) ? 4'b0001 : 4'b0000;
            checks++;
            if (gnt !== e) begin
                errors++;
                $display("FAIL oldest_gnt k=%0d got %b exp %b", k, gnt, e);
            end
            if (k == 5 || k == 6) begin
                checks++;
                if (gnt_id !== ((k == 5) ? 2'd3 : 2'd0)) begin
                    errors++;
                    $display("FAIL oldest_id k=%0d got %0d", k, gnt_id);
                end
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_hold_miss();
        for (int k = 0; k < 14; k++) begin
            req  = (k == 0) ? 4'b0100 : 4'b0000;
            hold = (k <= 12);
            tick();
            req = 4'b0000;
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL hold_gnt k=%0d got %b exp 0000", k, gnt);
            end
            checks++;
            if (miss !== (k == 10)) begin
                errors++;
                $display("FAIL hold_miss k=%0d got %b", k, miss);
            end
            if (k == 10) begin
                checks++;
                if (miss_id !== 2'd2) begin
                    errors++;
                    $display("FAIL hold_miss_id got %0d exp 2", miss_id);
                end
            end
            checks++;
            if (busy !== (k >= 1 && k <= 10)) begin
                errors++;
                $display("FAIL hold_busy k=%0d got %b", k, busy);
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_multi_miss();
        for (int k = 0; k < 13; k++) begin
            req  = (k == 0) ? 4'b1010 : 4'b0000;
            hold = (k <= 11);
            tick();
            req = 4'b0000;
            checks++;
            if (miss !== (k == 10)) begin
                errors++;
                $display("FAIL mmiss k=%0d got %b", k, miss);
            end
            if (k == 10) begin
                checks++;
                if (miss_id !== 2'd1) begin
                    errors++;
                    $display("FAIL mmiss_id got %0d exp 1", miss_id);
                end
            end
            if (k == 12) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL mmiss_busy got %b exp 0", busy);
                end
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_last_slot();
        logic [3:0] e;
        for (int k = 0; k < 13; k++) begin
            req  = (k == 0) ? 4'b0001 : 4'b0000;
            hold = (k <= 9);
            tick();
            req = 4'b0000;
            e = (k == 10) ? 4'b0001 : 4'b0000;
            checks++;
            if (gnt !== e) begin
                errors++;
                $display("FAIL last_gnt k=%0d got %b exp %b", k, gnt, e);
            end
            checks++;
            if (miss !== 1'b0) begin
                errors++;
                $display("FAIL last_miss k=%0d got %b exp 0", k, miss);
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_dup();
        logic [3:0] e;
        for (int k = 0; k < 12; k++) begin
            req = (k == 0 || k == 2) ? 4'b0001 : 4'b0000;
            tick();
            req = 4'b0000;
            e = (k == 3) ? 4'b0001 : 4'b0000;
            checks++;
            if (gnt !== e) begin
                errors++;
                $display("FAIL dup_gnt k=%0d got %b exp %b", k, gnt, e);
            end
            checks++;
            if (dup_err !== (k == 2)) begin
                errors++;
                $display("FAIL dup_err k=%0d got %b", k, dup_err);
            end
        end
    endtask

    task automatic test_rst_flight();
        logic [10:0] all;
        for (int k = 0; k < 20; k++) begin
            req = (k == 0) ? 4'b1000 : 4'b0000;
            rst = (k != 2);
            tick();
            req = 4'b0000;
            rst = 1'b1;
            if (k >= 2) begin
                all = {gnt, gnt_id, busy, dup_err, miss, miss_id};
                checks++;
                if (all !== 11'd0) begin
                    errors++;
                    $display("FAIL rst_flight k=%0d got %b exp 0", k, all);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all();
        test_stagger();
        test_oldest();
        test_hold_miss();
        test_multi_miss();
        test_last_slot();
        test_dup();
        test_rst_flight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/req_gnt_sched.md
# req_gnt_sched

Deadline-driven grant scheduler that shares one resource among `N_REQ` requesters. Every accepted request receives exactly one `gnt` pulse that is never earlier than `MIN_WAIT` cycles and never later than the end of a `WINDOW`-cycle grant window. The block sits between the requesting agents and the shared resource, and it guarantees the req/gnt latency contract by construction. When multiple requests are eligible, the oldest is granted first.

## Interface
- `N_REQ`, 4: number of requesters; must be ≤ `WINDOW`.
- `MIN_WAIT`, 3: edges after the req sample edge during which `gnt` stays low.
- `WINDOW`, 8: width in edges of the legal grant window.
- `AW`, `$clog2(MIN_WAIT+WINDOW+1)`: age counter width.

- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-low reset.
- `req` in `N_REQ`: single-cycle request pulses, one bit per requester.
- `hold` in 1: resource unavailable; no grant may be loaded while high.
- `gnt` out `N_REQ`: registered one-hot grant pulse, at most one bit high.
- `gnt_id` out `$clog2(N_REQ)`: index of the granted requester; valid while `|gnt`.
- `busy` out 1: registered; high while any request is pending.
- `dup_err` out 1: registered pulse; a req was dropped because it arrived while already pending.
- `miss` out 1: registered pulse; a pending request expired without a grant.
- `miss_id` out `$clog2(N_REQ)`: index of the expired requester; valid while `miss`.

## Operation
- Each requester has one state record: `pending` (1 bit) and `age` (`AW` bits).
- **Accepting a request:** req[i] sampled high at edge T with pending[i]=0 sets pending[i]=1 and age[i]=0. Age increments at every later edge while pending.
- **Duplicate request:** req[i] sampled high while pending[i]=1 is ignored, including on the edge that loads its own grant. That edge also loads `dup_err`=1.
- **Eligibility:** requester i is eligible when pending[i] and `MIN_WAIT-1` ≤ age[i] ≤ `MIN_WAIT+WINDOW-2`.
- **Grant selection:**
  - If `hold`=0 and any requester is eligible, pick the one with the largest age; on equal age, pick the lowest index.
  - At that edge, gnt[pick] is loaded 1, gnt_id is loaded with pick, and pending[pick] is cleared.
  - Otherwise gnt is loaded 0.
- **Expiry:**
  - A pending requester with age = `MIN_WAIT+WINDOW-2` that is not granted at this edge is cleared.
  - At the same edge, miss=1 and miss_id=i are loaded.
  - If several expire at once, report the lowest index in `miss_id`; all of them are cleared.
- **Guarantee:** with `hold`=0 throughout and `N_REQ` ≤ `WINDOW`, oldest-first selection ensures `miss` never fires.
- **Reset** (`rst`=0 sampled): clears all pending and age state. gnt, gnt_id, busy, dup_err, miss and miss_id all reset to 0. Requests in flight are discarded and never granted.
- **Arithmetic:** age saturates, so it never wraps; a pending age never exceeds `MIN_WAIT+WINDOW-2`.

## Timing
- A req sampled at edge T gives `gnt[i]`:
  - low at edges T+1…T+`MIN_WAIT`;
  - high at exactly one edge in T+`MIN_WAIT`+1 … T+`MIN_WAIT`+`WINDOW`;
  - then low until a new req is accepted.
- Minimum latency is 4 edges (req sample to gnt sample) at default parameters; maximum is 11.
- gnt is a 1-cycle pulse. At most one grant is issued per cycle, so two consecutive cycles may grant different requesters.
- All outputs are flop Q outputs; none has a combinational path from `req` or `hold`.
- `busy` reflects the registered pending state one edge after acceptance.

## Structure
- Package `req_gnt_pkg` holds the defaults (`MIN_WAIT`, `WINDOW`, `N_REQ`) and the typedef `req_state_t` {pending, age}.
- Sub-module `req_gnt_pick`: a combinational oldest-first selector. It takes eligible vectors and ages, and returns `valid` plus the winning index. Ties resolve to the lowest index.
- The top level holds the state array, the expiry logic and the output registers.

## Test plan
- req[0] pulse sampled at edge 10, hold=0 → gnt=4'b0001 and gnt_id=0 sampled only at edge 14; busy low again from edge 15.
- req=4'b1111 sampled at edge T → gnt[0], gnt[1], gnt[2], gnt[3] sampled at edges T+4, T+5, T+6, T+7; no miss.
- req[1] at T, req[0] at T+2 → gnt[1] at T+4, gnt[0] at T+6.
- req[2] at T, hold=1 from T to T+12 → no gnt; miss=1 and miss_id=2 sampled at T+11.
- req[0] at T and again at T+2 → dup_err sampled at T+3; exactly one gnt[0], at T+4.
- req[3] at T, rst=0 at edge T+2 → all outputs 0 from T+3; no gnt through T+20.
